// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter: FSM state encoding and the
// beat-counter width.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Width of the per-grant beat counter; MAX_BURST must fit in it.
  localparam int BEAT_W = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bus bundle between the requesters, the FIFO write port and the arbiter.
//
// Handshake: requester i transfers one beat in every cycle where
// req_valid[i] && req_ready[i]. req_ready is combinational from req_valid
// and fifo_full, and is high only for the current owner on cycles where
// fifo_wr_en is high, so a beat is accepted exactly when it is written.
// A requester should hold valid and data stable until accepted; dropping
// valid while owning the grant gives the grant up.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_REQ    = 4
);
  import fifo_arb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ID_W  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               fifo_full;
  logic [CNT_W-1:0]                   fifo_count;
  logic                               fifo_wr_en;
  logic [DATA_WIDTH-1:0]              fifo_wr_data;
  logic [ID_W-1:0]                    grant_id;
  logic                               busy;
  state_t                             dbg_state;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, fifo_full, fifo_count,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, dbg_state
  );

  // Requester / FIFO / environment side.
  modport master (
    output req_valid, req_data, fifo_full, fifo_count,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, dbg_state
  );

endinterface

// File: rtl/fifo_rr_select.sv
// Round-robin winner picker: scans the request vector starting at ptr_i,
// wrapping NUM_REQ-1 -> 0, and returns the first requester found.
module fifo_rr_select #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_o
);

  localparam int SW = ID_W + 1;

  logic [SW-1:0]   sum;
  logic [ID_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    winner_o = '0;
    any_o    = |req_i;
    sum      = '0;
    cand     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_i} + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      cand = sum[ID_W-1:0];
      if (req_i[cand]) winner_o = cand;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Multi-requester FIFO write arbiter. A round-robin winner owns the FIFO
// write port for up to MAX_BURST beats, stalls while the FIFO is full and
// loses the grant as soon as it drops valid.
// Optional statistics (per-requester beat counters, peak occupancy) are
// built when FIFO_WR_ARBITER_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic clk,
  input  logic rst_n,
  fifo_wr_arbiter_if.slave bus
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]      stat_beats,
  output logic [$clog2(DEPTH):0]        stat_peak
`endif
);

  localparam int              ID_W     = $clog2(NUM_REQ);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   next_ptr;
  logic              any_req;
  logic              own_valid;
  logic              wr_en;

  fifo_rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .req_i    (bus.req_valid),
    .ptr_i    (rr_ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  // Next-state logic: arbitrate in IDLE, count beats and decide exit in BURST.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    beats_d   = beats_q;
    own_valid = bus.req_valid[grant_q];
    next_ptr  = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);
    wr_en     = (state_q == BURST) && own_valid && !bus.fifo_full;
    case (state_q)
      IDLE: begin
        if (any_req && !bus.fifo_full) begin
          grant_d = winner;
          beats_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!own_valid) begin
          // Owner gave up: grant is lost, next arbitration starts after it.
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (wr_en) begin
          beats_d = beats_q + BEAT_W'(1);
          if (beats_d == BEAT_MAX) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
        // Full with valid owner: everything holds.
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: only the owner is ready, and only when a write happens.
  always_comb begin
    bus.fifo_wr_en   = wr_en;
    bus.req_ready    = '0;
    if (wr_en) bus.req_ready[grant_q] = 1'b1;
    bus.fifo_wr_data = (state_q == BURST) ? bus.req_data[grant_q] : '0;
    bus.grant_id     = grant_q;
    bus.busy         = (state_q == BURST);
    bus.dbg_state    = state_q;
  end

  // FSM, grant, round-robin pointer and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beats_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beats_q  <= beats_d;
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [NUM_REQ-1:0][15:0] stat_beats_q, stat_beats_d;
  logic [$clog2(DEPTH):0]   stat_peak_q, stat_peak_d;

  // Saturating accepted-beat counters and running peak of FIFO occupancy.
  always_comb begin
    stat_beats_d = stat_beats_q;
    if (wr_en && (stat_beats_q[grant_q] != 16'hFFFF))
      stat_beats_d[grant_q] = stat_beats_q[grant_q] + 16'd1;
    stat_peak_d = (bus.fifo_count > stat_peak_q) ? bus.fifo_count : stat_peak_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats_q <= '0;
      stat_peak_q  <= '0;
    end else begin
      stat_beats_q <= stat_beats_d;
      stat_peak_q  <= stat_peak_d;
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_peak  = stat_peak_q;
`else
  // Occupancy only feeds the statistics; it never gates writes.
  logic unused_fifo_count;
  assign unused_fifo_count = ^bus.fifo_count;
`endif

endmodule
